// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic GEMM engine: controller state encoding
// and the fixed end-to-end latency of the array.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Activation skew (rows) plus array traversal and deskew (columns).
   function automatic int calc_lat(input int rows, input int cols);
      return rows + cols;
   endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// One processing element of the weight-stationary array: holds a weight,
// forwards the activation one column right and the partial sum one row down.
module sa_mac_pe #(
   parameter int DW = 8,
   parameter int AW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_w_load,
   input  logic [DW-1:0] i_w_data,
   input  logic [DW-1:0] i_act,
   input  logic [AW-1:0] i_sum,
   output logic [DW-1:0] o_act,
   output logic [AW-1:0] o_sum
);

   logic [DW-1:0] r_w;
   logic [DW-1:0] r_act;
   logic [AW-1:0] r_sum;
   logic [AW-1:0] w_act_x;
   logic [AW-1:0] w_w_x;
   logic [AW-1:0] w_prod;

   // Both operands sign-extended to AW; the low AW bits of the product are
   // the signed product, wrapping modulo 2^AW like the accumulation.
   assign w_act_x = {{(AW-DW){i_act[DW-1]}}, i_act};
   assign w_w_x   = {{(AW-DW){r_w[DW-1]}}, r_w};
   assign w_prod  = w_act_x * w_w_x;

   // Weight capture on load enable; activation and partial sum advance every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w   <= '0;
         r_act <= '0;
         r_sum <= '0;
      end else begin
         if (i_w_load) r_w <= i_w_data;
         r_act <= i_act;
         r_sum <= i_sum + w_prod;
      end
   end

   assign o_act = r_act;
   assign o_sum = r_sum;

endmodule

// File: rtl/systolic_gemm_engine.sv
// Weight-stationary systolic GEMM engine: ROWS weight rows are loaded, then
// each activation vector a yields out[c] = sum_r a[r]*W[r][c] after a fixed
// ROWS+COLS cycles.
// Optional feature macro: SYSTOLIC_RELU_EN clamps negative output lanes to 0.
//
// Handshakes: a beat on w_* or a_* transfers on a rising edge where its valid
// and ready are both high; ready never depends on valid in the same cycle, and
// at most one of w_ready/a_ready is high (decided by controller state alone).
module systolic_gemm_engine
   import systolic_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = 8,
   parameter int AW   = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [COLS*DW-1:0]   w_data,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic                 a_last,
   input  logic [ROWS*DW-1:0]   a_data,
   output logic                 out_valid,
   output logic [COLS*AW-1:0]   out_data,
   output logic                 busy
);

   localparam int LAT = calc_lat(ROWS, COLS);
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW  = $clog2(LAT + 1);

   state_t          r_state;
   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_cnt;
   logic            r_w_ready;
   logic            r_a_ready;
   logic            r_busy;
   logic [LAT-1:0]  r_vld;

   logic            w_w_fire;
   logic            w_a_fire;
   logic [ROWS-1:0] w_row_ld;
   logic [DW-1:0]   w_act [ROWS][COLS];
   logic [AW-1:0]   w_sum [ROWS+1][COLS];
   logic [AW-1:0]   w_col [COLS];

   assign w_w_fire = w_valid && r_w_ready;
   assign w_a_fire = a_valid && r_a_ready;

   // Controller: weight load, streaming, drain; readies and busy are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_row     <= '0;
         r_cnt     <= '0;
         r_w_ready <= 1'b1;
         r_a_ready <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_w_fire) begin
                  r_busy <= 1'b1;
                  if (ROWS == 1) begin
                     r_state   <= RUN;
                     r_w_ready <= 1'b0;
                     r_a_ready <= 1'b1;
                  end else begin
                     r_state <= LOAD;
                     r_row   <= RW'(1);
                  end
               end
            end
            LOAD: begin
               if (w_w_fire) begin
                  if (r_row == RW'(ROWS-1)) begin
                     r_state   <= RUN;
                     r_row     <= '0;
                     r_w_ready <= 1'b0;
                     r_a_ready <= 1'b1;
                  end else begin
                     r_row <= r_row + RW'(1);
                  end
               end
            end
            RUN: begin
               if (w_a_fire && a_last) begin
                  r_state   <= DRAIN;
                  r_a_ready <= 1'b0;
                  r_cnt     <= '0;
               end
            end
            DRAIN: begin
               if (r_cnt == CW'(LAT-1)) begin
                  r_state   <= IDLE;
                  r_w_ready <= 1'b1;
                  r_busy    <= 1'b0;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state   <= IDLE;
               r_w_ready <= 1'b1;
               r_a_ready <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   // Valid bit shadows each accepted vector through the LAT-cycle datapath.
   always_ff @(posedge clk) begin
      if (rst) r_vld <= '0;
      else     r_vld <= {r_vld[LAT-2:0], w_a_fire};
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign w_row_ld[r] = w_w_fire && (r_row == RW'(r));
   end

   // Activation skew: lane r sees r extra register stages after the input stage.
   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      logic [DW-1:0] r_sk [r+1];
      // Input capture (bubbles enter as zero) followed by the skew shift chain.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i <= r; i++) r_sk[i] <= '0;
         end else begin
            r_sk[0] <= w_a_fire ? a_data[r*DW +: DW] : '0;
            for (int i = 1; i <= r; i++) r_sk[i] <= r_sk[i-1];
         end
      end
      assign w_act[r][0] = r_sk[r];
   end

   for (genvar c = 0; c < COLS; c++) begin : g_top
      assign w_sum[0][c] = '0;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
      for (genvar c = 0; c < COLS; c++) begin : g_pe_c
         logic [DW-1:0] w_act_right;
         sa_mac_pe #(.DW(DW), .AW(AW)) u_pe (
            .clk      (clk),
            .rst      (rst),
            .i_w_load (w_row_ld[r]),
            .i_w_data (w_data[c*DW +: DW]),
            .i_act    (w_act[r][c]),
            .i_sum    (w_sum[r][c]),
            .o_act    (w_act_right),
            .o_sum    (w_sum[r+1][c])
         );
         if (c < COLS-1) begin : g_link
            assign w_act[r][c+1] = w_act_right;
         end else begin : g_edge
            logic [DW-1:0] w_act_unused;
            assign w_act_unused = w_act_right;
         end
      end
   end

   // Output deskew: column c waits COLS-1-c cycles so all lanes align.
   for (genvar c = 0; c < COLS; c++) begin : g_dsk
      localparam int D = COLS - 1 - c;
      if (D == 0) begin : g_direct
         assign w_col[c] = w_sum[ROWS][c];
      end else begin : g_delay
         logic [AW-1:0] r_dk [D];
         // Deskew shift chain for this column.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < D; i++) r_dk[i] <= '0;
            end else begin
               r_dk[0] <= w_sum[ROWS][c];
               for (int i = 1; i < D; i++) r_dk[i] <= r_dk[i-1];
            end
         end
         assign w_col[c] = r_dk[D-1];
      end
`ifdef SYSTOLIC_RELU_EN
      assign out_data[c*AW +: AW] = w_col[c][AW-1] ? '0 : w_col[c];
`else
      assign out_data[c*AW +: AW] = w_col[c];
`endif
   end

   assign w_ready   = r_w_ready;
   assign a_ready   = r_a_ready;
   assign busy      = r_busy;
   assign out_valid = r_vld[LAT-1];

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Self-checking bench for systolic_gemm_engine (4x4, DW=8, AW=20).
module tb_systolic_gemm_engine;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DW   = 8;
   localparam int AW   = 20;
   localparam int LAT  = ROWS + COLS;
   localparam int OW   = COLS*AW;

   logic              clk;
   logic              rst;
   logic              w_valid;
   logic              w_ready;
   logic [COLS*DW-1:0] w_data;
   logic              a_valid;
   logic              a_ready;
   logic              a_last;
   logic [ROWS*DW-1:0] a_data;
   logic              out_valid;
   logic [OW-1:0]     out_data;
   logic              busy;

   systolic_gemm_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_last    (a_last),
      .a_data    (a_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   // scoreboard state
   logic [OW-1:0] exp_q[$];
   int            cyc_q[$];
   int            total = 0;
   int            bad   = 0;
   int            wm [ROWS][COLS];

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] model(input int a0, input int a1, input int a2, input int a3);
      int            a [ROWS];
      int            s;
      logic [AW-1:0] l;
      logic [OW-1:0] v;
      a = '{a0, a1, a2, a3};
      v = '0;
      for (int c = 0; c < COLS; c++) begin
         s = 0;
         for (int r = 0; r < ROWS; r++) s += a[r] * wm[r][c];
         l = s[AW-1:0];
`ifdef SYSTOLIC_RELU_EN
         if (l[AW-1]) l = '0;
`endif
         v[c*AW +: AW] = l;
      end
      return v;
   endfunction

   function automatic logic [ROWS*DW-1:0] pack_a(input int a0, input int a1, input int a2, input int a3);
      int                 a [ROWS];
      logic [ROWS*DW-1:0] v;
      a = '{a0, a1, a2, a3};
      for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = a[r][DW-1:0];
      return v;
   endfunction

   task automatic set_ident(input int k);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = (r == c) ? k : 0;
   endtask

   task automatic set_rowval();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = r + 1;
   endtask

   task automatic set_all(input int k);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = k;
   endtask

   // driver tasks (all start and end on a falling edge)
   task automatic load_w();
      int n;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) w_data[c*DW +: DW] = wm[r][c][DW-1:0];
         w_valid = 1'b1;
         n = 0;
         while (!w_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("w_accept", OW'(w_ready), OW'(1));
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   task automatic send_vec(input int a0, input int a1, input int a2, input int a3,
                           input bit last, output int acc);
      int n;
      a_data  = pack_a(a0, a1, a2, a3);
      a_last  = last;
      a_valid = 1'b1;
      n = 0;
      while (!a_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("a_accept", OW'(a_ready), OW'(1));
      exp_q.push_back(model(a0, a1, a2, a3));
      cyc_q.push_back(cyc + LAT);
      acc = cyc;
      @(negedge clk);
      a_valid = 1'b0;
      a_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", OW'(busy), OW'(0));
   endtask

   // output monitor: pops the scoreboard on each result beat
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexp_valid", OW'(out_valid), OW'(0));
         end else begin
            chk("out_cycle", OW'(cyc), OW'(cyc_q.pop_front()));
            chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   int t;
   int nv;

   initial begin
      rst = 1'b1; w_valid = 1'b0; w_data = '0;
      a_valid = 1'b0; a_last = 1'b0; a_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_w_ready", OW'(w_ready), OW'(1));
      chk("rst_a_ready", OW'(a_ready), OW'(0));
      chk("rst_out_valid", OW'(out_valid), OW'(0));
      chk("rst_out_data", out_data, OW'(0));
      chk("rst_busy", OW'(busy), OW'(0));
      rst = 1'b0;
      @(negedge clk);

      // identity weights, single vector, exact latency and drain length
      set_ident(1);
      load_w();
      chk("run_w_ready", OW'(w_ready), OW'(0));
      chk("run_a_ready", OW'(a_ready), OW'(1));
      send_vec(1, 2, 3, 4, 1'b1, t);
      chk("drain_a_ready", OW'(a_ready), OW'(0));
      chk("drain_w_ready", OW'(w_ready), OW'(0));
      while (cyc < t + LAT) @(negedge clk);
      chk("drain_busy_end", OW'(busy), OW'(1));
      @(negedge clk);
      chk("idle_busy", OW'(busy), OW'(0));
      chk("idle_w_ready", OW'(w_ready), OW'(1));

      // row-valued weights, back-to-back vectors including a negative lane
      set_rowval();
      load_w();
      send_vec(1, 1, 1, 1, 1'b0, t);
      send_vec(2, 0, 0, -1, 1'b1, t);
      wait_idle();

      // extreme operands: -128 * -128 summed over four rows
      set_all(-128);
      load_w();
      send_vec(-128, -128, -128, -128, 1'b1, t);
      wait_idle();

      // bubbles: valid pattern 1,0,0,1
      load_w();
      send_vec(-128, -128, -128, -128, 1'b0, t);
      repeat (2) @(negedge clk);
      send_vec(-128, -128, -128, -128, 1'b1, t);
      wait_idle();

      // negative identity: negative results (clamped when ReLU is built in)
      set_ident(-1);
      load_w();
      send_vec(1, 2, 3, 4, 1'b1, t);
      wait_idle();

      // activation offered in IDLE is ignored
      a_data = pack_a(5, 6, 7, 8); a_last = 1'b1; a_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("idle_a_ready", OW'(a_ready), OW'(0));
         @(negedge clk);
      end
      a_valid = 1'b0; a_last = 1'b0;

      // weight beats held during RUN are ignored
      set_ident(1);
      load_w();
      w_valid = 1'b1;
      w_data  = 32'hA5A5_A5A5;
      for (int i = 0; i < 3; i++) begin
         chk("run_w_hold_ready", OW'(w_ready), OW'(0));
         @(negedge clk);
      end
      send_vec(1, 2, 3, 4, 1'b1, t);
      w_valid = 1'b0;
      wait_idle();

      // reset two cycles after an accepted RUN beat discards it
      load_w();
      a_data = pack_a(9, 9, 9, 9); a_last = 1'b0; a_valid = 1'b1;
      chk("pre_rst_a_ready", OW'(a_ready), OW'(1));
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      for (int i = 0; i < LAT + 4; i++) begin
         if (out_valid) nv++;
         @(negedge clk);
      end
      chk("rst_no_out", OW'(nv), OW'(0));
      chk("post_rst_busy", OW'(busy), OW'(0));
      chk("post_rst_w_ready", OW'(w_ready), OW'(1));

      nv = 0;
      while (exp_q.size() != 0 && nv < 40) begin
         @(negedge clk);
         nv++;
      end
      chk("q_empty", OW'(exp_q.size()), OW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_gemm_engine.md
SYSTOLIC_GEMM_ENGINE -- requirements
Module: systolic_gemm_engine

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
  ROWS, 4, array rows (activation lanes, reduction depth).
  COLS, 4, array columns (output lanes).
  DW, 8, signed activation/weight width.
  AW, 20, signed accumulator/result width; AW >= 2*DW + clog2(ROWS).
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clk  in  1  sole clock; all logic on the rising edge.
  rst  in  1  reset, synchronous and active-high.
  w_valid  in  1  weight row beat offered.
  w_ready  out  1  weight beat accepted when w_valid && w_ready.
  w_data  in  COLS*DW  one weight row W[r][0..COLS-1]; lane c at [c*DW +: DW].
  a_valid  in  1  activation vector offered.
  a_ready  out  1  activation beat accepted when a_valid && a_ready.
  a_last  in  1  final vector of the batch; qualified by the accepted beat.
  a_data  in  ROWS*DW  activation vector; lane r at [r*DW +: DW].
  out_valid  out  1  result vector valid, one cycle per vector.
  out_data  out  COLS*AW  result; lane c = sum over r of a[r]*W[r][c].
  busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, RUN and DRAIN.
REQ-004 IDLE: w_ready=1, a_ready=0; an accepted weight beat is stored as row 0, and the FSM goes to LOAD, or straight to RUN if ROWS=1.
REQ-005 LOAD: w_ready=1, a_ready=0; beats fill rows 1..ROWS-1 in order; accepting row ROWS-1 goes to RUN; without w_valid the FSM holds indefinitely.
REQ-006 RUN: w_ready=0, a_ready=1; each accepted vector enters the array; gaps in a_valid are permitted, and a valid bit travels with the data; an accepted beat with a_last=1 goes to DRAIN.
REQ-007 DRAIN: w_ready=0, a_ready=0; a counter runs LAT cycles after the last beat and then returns to IDLE; weights are retained, and a new batch needs a full reload.
REQ-008 Latency SHALL be LAT = ROWS+COLS cycles, fixed: a vector accepted at cycle t yields out_valid=1 at cycle t+LAT with all COLS lanes aligned.
REQ-009 Each activation lane r SHALL be skewed by r cycles, and each output lane c deskewed by COLS-1-c cycles.
REQ-010 Each PE SHALL be a signed DW x DW multiply, sign-extended to AW, plus the incoming partial sum.
REQ-011 Wrap on overflow SHALL be modulo 2^AW; no overflow flag.
REQ-012 Output ordering SHALL equal input ordering, and bubbles SHALL propagate as out_valid=0.
REQ-013 Weight beats offered in RUN/DRAIN SHALL be ignored; activation beats offered in IDLE/LOAD/DRAIN SHALL be ignored.
REQ-014 Simultaneous w_valid and a_valid SHALL be resolved by state alone; exactly one ready is high at a time, and none in DRAIN.

Reset
REQ-015 While rst=1 at a clock edge, the FSM SHALL go to IDLE and all weights, skew/deskew registers, partial sums, valid bits and counters SHALL clear to 0.
REQ-016 Reset values SHALL be: w_ready=1, a_ready=0, out_valid=0, out_data=0, busy=0.
REQ-017 Reset mid-LOAD/RUN/DRAIN SHALL discard all in-flight vectors, with no out_valid after reset deasserts.

Configuration
REQ-018 The macro SYSTOLIC_RELU_EN SHALL control an output activation function.
REQ-019 With SYSTOLIC_RELU_EN defined, any output lane with a negative (MSB=1) result SHALL present 0; non-negative lanes pass unchanged; latency is unchanged.
REQ-020 Without SYSTOLIC_RELU_EN, results SHALL pass unmodified.

Structure
REQ-021 A shared package systolic_pkg SHALL hold the FSM state typedef (IDLE/LOAD/RUN/DRAIN) and the LAT computation function.
REQ-022 One sub-module SHALL be used: sa_mac_pe, which holds the weight register with load enable, the registered activation pass-right, and the registered sum pass-down; it is instantiated ROWS x COLS times.

Verification (ROWS=COLS=4, DW=8, AW=20)
REQ-023 Load identity W, then send a=[1,2,3,4] with a_last -> out=[1,2,3,4] exactly 8 cycles after acceptance; FSM then back to IDLE.
REQ-024 W[r][c]=r+1 for all c; send back-to-back vectors [1,1,1,1] and [2,0,0,-1] -> outputs [10,10,10,10] then [-2,-2,-2,-2] on consecutive cycles.
REQ-025 W all -128, a all -128 -> every lane = 65536, with no wrap at AW=20.
REQ-026 Same W and a_data with a_valid pattern 1,0,0,1 -> out_valid pattern 1,0,0,1 with matching values; with SYSTOLIC_RELU_EN, W=-identity and a=[1,2,3,4] -> out=[0,0,0,0], and without the macro -> out=[-1,-2,-3,-4].
REQ-027 w_valid held high during RUN -> weights unchanged and w_ready=0.
REQ-028 rst pulsed 2 cycles after a RUN beat -> out_valid stays 0 and FSM returns to IDLE.
